// File: rtl/chip_select_pkg.sv
// Shared types and constants for the chip-select controller:
// FSM state encoding, wait-counter width and region descriptors.
package chip_select_pkg;

    localparam int unsigned WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE,
        ST_ERROR
    } state_t;

    typedef struct packed {
        logic [31:0]       base;
        logic [31:0]       limit;
        logic [WAIT_W-1:0] wait_cycles;
    } region_t;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chip_select_ctrl_region_decoder.sv
// Combinational priority decoder: reports whether the address falls in any
// region and the lowest-index region that contains it.
module region_decoder
    import chip_select_pkg::*;
#(
    parameter int unsigned N_REG  = 2,
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned SEL_W  = 1
) (
    input  logic [ADDR_W-1:0]        i_address,
    input  region_t [N_REG-1:0]      i_regions,
    output logic                     o_hit,
    output logic [SEL_W-1:0]         o_idx
);

    logic [31:0] w_addr;

    // Ascending scan that stops updating after the first hit gives lowest-index priority.
    always_comb begin
        w_addr = 32'(i_address);
        o_hit  = 1'b0;
        o_idx  = '0;
        for (int unsigned i = 0; i < N_REG; i++) begin
            if (!o_hit && (w_addr >= i_regions[i].base) && (w_addr <= i_regions[i].limit)) begin
                o_hit = 1'b1;
                o_idx = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/chip_select_ctrl.sv
// Address-decoded chip-select controller: per-region chip selects and write
// strobes with programmable wait states, registered read data and error count.
module chip_select_ctrl
    import chip_select_pkg::*;
#(
    parameter int unsigned ADDR_W            = 19,
    parameter int unsigned DATA_W            = 32,
    parameter int unsigned N_REG             = 2,
    parameter int unsigned REG_BASE  [N_REG] = '{0, 64},
    parameter int unsigned REG_LIMIT [N_REG] = '{63, 127},
    parameter int unsigned REG_WAIT  [N_REG] = '{0, 2}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req,
    input  logic [ADDR_W-1:0]             address,
    input  logic                          memWrite,
    input  logic [N_REG*DATA_W-1:0]       rdata_i,
    output logic [N_REG-1:0]              cs_o,
    output logic [N_REG-1:0]              we_o,
    output logic [sel_width(N_REG)-1:0]   memSel,
    output logic [DATA_W-1:0]             rdata_o,
    output logic                          ack,
    output logic                          err,
    output logic                          busy,
    output logic [7:0]                    err_cnt
);

    localparam int unsigned SEL_W = sel_width(N_REG);

    state_t             r_state;
    state_t             w_next;
    logic [SEL_W-1:0]   r_region;
    logic               r_write;
    logic [WAIT_W-1:0]  r_wait;
    logic [SEL_W-1:0]   r_mem_sel;
    logic [DATA_W-1:0]  r_rdata;
    logic [7:0]         r_err_cnt;

    region_t [N_REG-1:0] w_regions;
    logic               w_hit;
    logic [SEL_W-1:0]   w_idx;
    logic               w_last;
    logic [DATA_W-1:0]  w_rd_sel;

    always_comb begin
        w_regions = '0;
        for (int unsigned i = 0; i < N_REG; i++) begin
            w_regions[i].base        = 32'(REG_BASE[i]);
            w_regions[i].limit       = 32'(REG_LIMIT[i]);
            w_regions[i].wait_cycles = WAIT_W'(REG_WAIT[i]);
        end
    end

    region_decoder #(
        .N_REG  (N_REG),
        .ADDR_W (ADDR_W),
        .SEL_W  (SEL_W)
    ) u_decoder (
        .i_address (address),
        .i_regions (w_regions),
        .o_hit     (w_hit),
        .o_idx     (w_idx)
    );

    assign w_last   = (r_wait == '0);
    assign w_rd_sel = rdata_i[r_region*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (req) w_next = w_hit ? ST_ACCESS : ST_ERROR;
            ST_ACCESS: if (w_last) w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            ST_ERROR:  w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Error count advances on entry to ERROR so it is already visible during the err pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_region  <= '0;
            r_write   <= 1'b0;
            r_wait    <= '0;
            r_mem_sel <= '0;
            r_rdata   <= '0;
            r_err_cnt <= '0;
        end else if (r_state == ST_IDLE && req) begin
            if (w_hit) begin
                r_region  <= w_idx;
                r_write   <= memWrite;
                r_wait    <= w_regions[w_idx].wait_cycles;
                r_mem_sel <= w_idx;
            end else if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end else if (r_state == ST_ACCESS) begin
            if (w_last) begin
                if (!r_write) r_rdata <= w_rd_sel;
            end else begin
                r_wait <= r_wait - WAIT_W'(1);
            end
        end
    end

    always_comb begin
        cs_o = '0;
        we_o = '0;
        if (r_state == ST_ACCESS) begin
            cs_o[r_region] = 1'b1;
            we_o[r_region] = r_write && w_last;
        end
    end

    assign ack     = (r_state == ST_DONE) || (r_state == ST_ERROR);
    assign err     = (r_state == ST_ERROR);
    assign busy    = (r_state != ST_IDLE);
    assign memSel  = r_mem_sel;
    assign rdata_o = r_rdata;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_chip_select_ctrl.sv
// Self-checking bench for chip_select_ctrl with default parameters, using a
// transaction-level model of regions, wait states, read data and error count.
module tb_chip_select_ctrl;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 32;
    localparam int N_REG  = 2;

    logic                      clk      = 1'b0;
    logic                      rst_n    = 1'b0;
    logic                      req      = 1'b0;
    logic [ADDR_W-1:0]         address  = '0;
    logic                      memWrite = 1'b0;
    logic [N_REG*DATA_W-1:0]   rdata_i  = '0;
    logic [N_REG-1:0]          cs_o;
    logic [N_REG-1:0]          we_o;
    logic                      memSel;
    logic [DATA_W-1:0]         rdata_o;
    logic                      ack;
    logic                      err;
    logic                      busy;
    logic [7:0]                err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    int          BASE  [2] = '{0, 64};
    int          LIMIT [2] = '{63, 127};
    int          WT    [2] = '{0, 2};
    int          exp_err   = 0;
    logic [31:0] exp_rdata = '0;
    logic        exp_sel   = 1'b0;

    always #5 clk = ~clk;

    chip_select_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .N_REG  (N_REG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .address  (address),
        .memWrite (memWrite),
        .rdata_i  (rdata_i),
        .cs_o     (cs_o),
        .we_o     (we_o),
        .memSel   (memSel),
        .rdata_o  (rdata_o),
        .ack      (ack),
        .err      (err),
        .busy     (busy),
        .err_cnt  (err_cnt)
    );

    function automatic int region_of(input int a);
        for (int i = 0; i < 2; i++)
            if (a >= BASE[i] && a <= LIMIT[i]) return i;
        return -1;
    endfunction

    function automatic int sat_inc(input int c);
        return (c >= 255) ? 255 : c + 1;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for exactly one edge; afterwards the bench observes cycle 1.
    task automatic issue(input int a, input bit w, input logic [31:0] d0, input logic [31:0] d1);
        address  = ADDR_W'(a);
        memWrite = w;
        rdata_i  = {d1, d0};
        req      = 1'b1;
        next_cycle();
        req      = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({cs_o, we_o, memSel, rdata_o, ack, err, busy, err_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got cs=%b we=%b sel=%b rd=%h ack=%b err=%b busy=%b cnt=%0d expected all zero",
                     cs_o, we_o, memSel, rdata_o, ack, err, busy, err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        n_cmp++;
        if ({busy, ack, cs_o} !== 4'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got busy=%b ack=%b cs=%b expected 0 0 00", busy, ack, cs_o);
        end
    endtask

    task automatic test_write_hits();
        issue(50, 1'b1, 32'h0, 32'h0);
        n_cmp++;
        if ({cs_o, we_o, ack, memSel} !== {2'b01, 2'b01, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL write50_c1: got cs=%b we=%b ack=%b sel=%b expected 01 01 0 0", cs_o, we_o, ack, memSel);
        end
        next_cycle();
        n_cmp++;
        if ({cs_o, we_o, ack, err, busy} !== {2'b00, 2'b00, 1'b1, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL write50_c2: got cs=%b we=%b ack=%b err=%b busy=%b expected 00 00 1 0 1",
                     cs_o, we_o, ack, err, busy);
        end
        next_cycle();
        n_cmp++;
        if ({busy, ack} !== 2'b00) begin
            n_bad++;
            $display("FAIL write50_idle: got busy=%b ack=%b expected 0 0", busy, ack);
        end

        issue(77, 1'b1, 32'h0, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            n_cmp++;
            if ({cs_o, we_o, ack} !== {2'b10, (c == 3) ? 2'b10 : 2'b00, 1'b0}) begin
                n_bad++;
                $display("FAIL write77_c%0d: got cs=%b we=%b ack=%b expected 10 %s 0",
                         c, cs_o, we_o, ack, (c == 3) ? "10" : "00");
            end
            next_cycle();
        end
        n_cmp++;
        if ({cs_o, ack, memSel, rdata_o} !== {2'b00, 1'b1, 1'b1, 32'h0}) begin
            n_bad++;
            $display("FAIL write77_c4: got cs=%b ack=%b sel=%b rd=%h expected 00 1 1 00000000",
                     cs_o, ack, memSel, rdata_o);
        end
        next_cycle();
        exp_sel = 1'b1;
    endtask

    task automatic test_read();
        logic [31:0] d0;
        d0 = $urandom;
        issue(10, 1'b0, d0, 32'h1234_5678);
        n_cmp++;
        if ({cs_o, we_o, memSel} !== {2'b01, 2'b00, 1'b0}) begin
            n_bad++;
            $display("FAIL read10_c1: got cs=%b we=%b sel=%b expected 01 00 0", cs_o, we_o, memSel);
        end
        next_cycle();
        n_cmp++;
        if (ack !== 1'b1 || rdata_o !== d0) begin
            n_bad++;
            $display("FAIL read10_c2: got ack=%b rd=%h expected 1 %h", ack, rdata_o, d0);
        end
        next_cycle();

        issue(77, 1'b0, 32'hFFFF_FFFF, 32'h0000_00A5);
        for (int c = 1; c <= 3; c++) begin
            n_cmp++;
            if ({cs_o, we_o, ack} !== {2'b10, 2'b00, 1'b0}) begin
                n_bad++;
                $display("FAIL read77_c%0d: got cs=%b we=%b ack=%b expected 10 00 0", c, cs_o, we_o, ack);
            end
            next_cycle();
        end
        n_cmp++;
        if ({ack, we_o, memSel} !== {1'b1, 2'b00, 1'b1} || rdata_o !== 32'hA5) begin
            n_bad++;
            $display("FAIL read77_c4: got ack=%b we=%b sel=%b rd=%h expected 1 00 1 000000a5",
                     ack, we_o, memSel, rdata_o);
        end
        rdata_i = '1;
        next_cycle();
        n_cmp++;
        if (rdata_o !== 32'hA5) begin
            n_bad++;
            $display("FAIL read_hold: got rd=%h expected 000000a5", rdata_o);
        end
        exp_rdata = 32'hA5;
        exp_sel   = 1'b1;
    endtask

    task automatic test_miss();
        issue(200, 1'b1, 32'h0, 32'h0);
        exp_err = sat_inc(exp_err);
        n_cmp++;
        if ({err, ack, cs_o, we_o, memSel} !== {1'b1, 1'b1, 2'b00, 2'b00, exp_sel} || err_cnt !== 8'(exp_err)) begin
            n_bad++;
            $display("FAIL miss200_c1: got err=%b ack=%b cs=%b we=%b sel=%b cnt=%0d expected 1 1 00 00 %b %0d",
                     err, ack, cs_o, we_o, memSel, err_cnt, exp_sel, exp_err);
        end
        next_cycle();
        n_cmp++;
        if ({err, ack, busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL miss200_c2: got err=%b ack=%b busy=%b expected 0 0 0", err, ack, busy);
        end
    endtask

    task automatic test_busy_ignore();
        issue(77, 1'b1, 32'h0, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            n_cmp++;
            if ({cs_o, busy} !== {2'b10, 1'b1}) begin
                n_bad++;
                $display("FAIL busy_c%0d: got cs=%b busy=%b expected 10 1", c, cs_o, busy);
            end
            address = ADDR_W'(50);
            req     = 1'b1;
            next_cycle();
        end
        n_cmp++;
        if ({ack, memSel} !== 2'b11) begin
            n_bad++;
            $display("FAIL busy_c4: got ack=%b sel=%b expected 1 1", ack, memSel);
        end
        next_cycle();
        req = 1'b0;
        n_cmp++;
        if ({busy, ack, cs_o, memSel} !== {1'b0, 1'b0, 2'b00, 1'b1}) begin
            n_bad++;
            $display("FAIL busy_c5: got busy=%b ack=%b cs=%b sel=%b expected 0 0 00 1", busy, ack, cs_o, memSel);
        end
        exp_sel = 1'b1;
    endtask

    task automatic test_random();
        int          a;
        int          r;
        bit          w;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  ecs;
        logic [1:0]  ewe;
        for (int t = 0; t < 80; t++) begin
            a  = $urandom_range(255, 0);
            w  = 1'($urandom);
            d0 = $urandom;
            d1 = $urandom;
            r  = region_of(a);
            issue(a, w, d0, d1);
            if (r < 0) begin
                exp_err = sat_inc(exp_err);
                n_cmp++;
                if ({err, ack, cs_o, we_o, memSel} !== {1'b1, 1'b1, 2'b00, 2'b00, exp_sel} || err_cnt !== 8'(exp_err)) begin
                    n_bad++;
                    $display("FAIL rnd_miss a=%0d: got err=%b ack=%b cs=%b sel=%b cnt=%0d expected 1 1 00 %b %0d",
                             a, err, ack, cs_o, memSel, err_cnt, exp_sel, exp_err);
                end
            end else begin
                ecs = (r == 0) ? 2'b01 : 2'b10;
                for (int c = 1; c <= WT[r] + 1; c++) begin
                    ewe = (w && c == WT[r] + 1) ? ecs : 2'b00;
                    n_cmp++;
                    if ({cs_o, we_o, ack, err, busy} !== {ecs, ewe, 1'b0, 1'b0, 1'b1}) begin
                        n_bad++;
                        $display("FAIL rnd_access a=%0d c=%0d: got cs=%b we=%b ack=%b err=%b busy=%b expected %b %b 0 0 1",
                                 a, c, cs_o, we_o, ack, err, busy, ecs, ewe);
                    end
                    next_cycle();
                end
                if (!w) exp_rdata = (r == 0) ? d0 : d1;
                exp_sel = (r == 1);
                n_cmp++;
                if ({ack, err, cs_o, memSel} !== {1'b1, 1'b0, 2'b00, exp_sel} || rdata_o !== exp_rdata) begin
                    n_bad++;
                    $display("FAIL rnd_done a=%0d w=%b: got ack=%b err=%b cs=%b sel=%b rd=%h expected 1 0 00 %b %h",
                             a, w, ack, err, cs_o, memSel, rdata_o, exp_sel, exp_rdata);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_saturation();
        for (int t = 0; t < 300; t++) begin
            issue(int'($urandom_range(524287, 128)), 1'($urandom), 32'h0, 32'h0);
            exp_err = sat_inc(exp_err);
            n_cmp++;
            if (err !== 1'b1 || err_cnt !== 8'(exp_err)) begin
                n_bad++;
                $display("FAIL sat_miss%0d: got err=%b cnt=%0d expected 1 %0d", t, err, err_cnt, exp_err);
            end
            next_cycle();
        end
        n_cmp++;
        if (err_cnt !== 8'd255) begin
            n_bad++;
            $display("FAIL sat_final: got cnt=%0d expected 255", err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        issue(77, 1'b0, 32'h0, 32'h5A5A_5A5A);
        next_cycle();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cs_o, we_o, memSel, rdata_o, ack, err, busy, err_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: got cs=%b we=%b sel=%b rd=%h ack=%b err=%b busy=%b cnt=%0d expected all zero",
                     cs_o, we_o, memSel, rdata_o, ack, err, busy, err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            n_cmp++;
            if ({ack, busy, cs_o} !== 4'b0) begin
                n_bad++;
                $display("FAIL reset_noack c=%0d: got ack=%b busy=%b cs=%b expected 0 0 00", c, ack, busy, cs_o);
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(50, 1'b1, 32'h0, 32'h0);
        n_cmp++;
        if ({cs_o, we_o, busy} !== {2'b01, 2'b01, 1'b1}) begin
            n_bad++;
            $display("FAIL first_req_after_reset: got cs=%b we=%b busy=%b expected 01 01 1", cs_o, we_o, busy);
        end
        next_cycle();
        n_cmp++;
        if ({ack, err_cnt} !== {1'b1, 8'd0}) begin
            n_bad++;
            $display("FAIL first_req_ack: got ack=%b cnt=%0d expected 1 0", ack, err_cnt);
        end
        next_cycle();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_hits();
        test_read();
        test_miss();
        test_busy_ignore();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/chip_select_ctrl.md
CHIP_SELECT_CTRL -- requirements
Module: chip_select_ctrl

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 19, meaning address width.
REQ-002 The module SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 The module SHALL have parameter N_REG, default 2, range 1..8, meaning number of decoded regions.
REQ-004 The module SHALL have parameter REG_BASE, default {0,64}, meaning per-region inclusive base addresses.
REQ-005 The module SHALL have parameter REG_LIMIT, default {63,127}, meaning per-region inclusive limit addresses.
REQ-006 The module SHALL have parameter REG_WAIT, default {0,2}, range 0..15, meaning per-region wait states.
REQ-007 Port clk, input, 1, is the single clock; all logic SHALL be rising-edge.
REQ-008 Port rst_n, input, 1, SHALL be an asynchronous, active-low reset.
REQ-009 Port req, input, 1: transaction request, sampled only in IDLE.
REQ-010 Port address, input, ADDR_W: transaction address.
REQ-011 Port memWrite, input, 1: 1 = write, 0 = read.
REQ-012 Port rdata_i, input, N_REG*DATA_W: flattened per-region read data.
REQ-013 Port cs_o, output, N_REG: per-region chip select.
REQ-014 Port we_o, output, N_REG: per-region write strobe (successor of en1/en2).
REQ-015 Port memSel, output, max(1,clog2(N_REG)): index of the last decoded region.
REQ-016 Port rdata_o, output, DATA_W: registered read data.
REQ-017 Port ack, output, 1: one-cycle completion pulse.
REQ-018 Port err, output, 1: one-cycle decode-error pulse, coincident with ack.
REQ-019 Port busy, output, 1: high whenever the state is not IDLE.
REQ-020 Port err_cnt, output, 8: saturating count of decode errors.

Function
REQ-021 The FSM SHALL have states IDLE, ACCESS, DONE, ERROR.
REQ-022 Decode: a region matches when REG_BASE <= address <= REG_LIMIT; with overlap, the lowest index SHALL win.
REQ-023 IDLE with req=1 and a match SHALL latch address, memWrite and region index, load the wait counter with REG_WAIT[region], set memSel, and go to ACCESS.
REQ-024 IDLE with req=1 and no match SHALL go to ERROR; cs_o, we_o and memSel SHALL stay unchanged.
REQ-025 In ACCESS, cs_o SHALL be one-hot on the latched region for exactly REG_WAIT+1 cycles while the counter decrements to 0.
REQ-026 we_o[region] SHALL be high only in the final ACCESS cycle, and only if the latched memWrite=1; a read SHALL never assert we_o.
REQ-027 For a read, rdata_o SHALL capture rdata_i[region] at the edge that ends the final ACCESS cycle and hold it until the next read.
REQ-028 DONE SHALL assert ack for one cycle with cs_o=0, then return to IDLE.
REQ-029 ERROR SHALL assert ack=1 and err=1 for one cycle, increment err_cnt (saturating at 255), then return to IDLE.
REQ-030 Latency: req at edge k SHALL produce ack in cycle k+REG_WAIT+2 for a hit, and in cycle k+1 for a miss.
REQ-031 req while busy=1 SHALL be ignored, not queued.
REQ-032 memSel SHALL hold its value until the next successful decode.

Reset
REQ-033 rst_n=0 SHALL force, asynchronously and immediately, state=IDLE and cs_o, we_o, memSel, rdata_o, ack, err, busy and err_cnt to 0, including mid-transaction; the aborted transaction SHALL be dropped with no ack.
REQ-034 After rst_n deasserts, the first req SHALL be accepted at the next rising edge.

Structure
REQ-035 Package chip_select_pkg SHALL hold the state enum, the WAIT_W=4 constant and the region-descriptor typedef (base, limit, wait).
REQ-036 A combinational sub-module region_decoder SHALL do the priority match and output hit plus index.

Verification (N_REG=2, defaults)
REQ-037 Write to address 50 at edge 0 -> cs_o=01 and we_o=01 in cycle 1, ack in cycle 2, memSel=0.
REQ-038 Write to address 77 -> cs_o=10 for 3 cycles, we_o=10 only in the third, ack in cycle 4, memSel=1.
REQ-039 Read from address 77 with rdata_i[1]=0xA5 -> we_o stays 00 throughout, rdata_o=0xA5 with ack.
REQ-040 Request to address 200 -> err=ack=1 in cycle 1, cs_o=00, err_cnt=1; 300 such misses -> err_cnt=255.
REQ-041 req while busy is ignored; rst_n low during ACCESS of 77 -> all outputs 0 immediately, no ack follows.
